// File: rtl/daisy_link_ctrl_if.sv
// System-bus connection between the link bring-up sequencer (master) and the
// daisy block register space (slave).
interface daisy_link_ctrl_if;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_sel_o;
  logic        m_wen_o;
  logic        m_ren_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;
  logic        m_err_i;

  modport master (
    output m_addr_o, m_wdata_o, m_sel_o, m_wen_o, m_ren_o,
    input  m_rdata_i, m_ack_i, m_err_i
  );

  modport slave (
    input  m_addr_o, m_wdata_o, m_sel_o, m_wen_o, m_ren_o,
    output m_rdata_i, m_ack_i, m_err_i
  );
endinterface

// File: rtl/daisy_link_ctrl.sv
// Daisy-chain link bring-up sequencer: enables TX/RX, trains, runs a PRBS test
// window, switches to working data, and retries or tears down on request.
module daisy_link_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned TEST_CYC  = 65536,
  parameter int unsigned MIN_DAT   = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned ACK_TO    = 16
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic               start_i,
  input  logic               stop_i,
  daisy_link_ctrl_if.master  bus,
  output logic               link_up_o,
  output logic               busy_o,
  output logic               fail_o,
  output logic [3:0]         state_o,
  output logic [1:0]         retry_o,
  output logic [31:0]        tst_err_o
);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam int unsigned WW = $clog2(TEST_CYC + 1);
  localparam int unsigned TW = $clog2(ACK_TO + 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_EN      = 4'd1,  S_SEL_TRN = 4'd2,  S_TRN_ON  = 4'd3,
    S_POLL    = 4'd4,  S_TRN_OFF = 4'd5,  S_SEL_TST = 4'd6,  S_CLR     = 4'd7,
    S_WAIT    = 4'd8,  S_RD_ERR  = 4'd9,  S_RD_DAT  = 4'd10, S_SEL_WRK = 4'd11,
    S_UP      = 4'd12, S_RETRY   = 4'd13, S_DOWN    = 4'd14, S_FAIL    = 4'd15
  } state_e;

  state_e        state_q, state_d;
  logic          step_q, step_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    retry_q, retry_d;
  logic          fail_q, fail_d;
  logic [31:0]   tst_err_q, tst_err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          start_q;
  logic          stop_pend_q, stop_pend_d;
  logic          busy_q, link_up_q;

  logic          start_edge, stop_live, stop_now;
  logic          has_bus, req_rd;
  logic [7:0]    req_off;
  logic [31:0]   req_dat;

  assign start_edge = start_i & ~start_q;
  assign stop_live  = stop_i && (state_q != S_IDLE) && (state_q != S_DOWN);
  assign stop_now   = stop_pend_q | stop_live;

  // step_q selects the second access of the two-write states.
  always_comb begin
    has_bus = 1'b1;
    req_rd  = 1'b0;
    req_off = '0;
    req_dat = '0;
    case (state_q)
      S_EN:      req_dat = 32'd3;
      S_SEL_TRN: begin req_off = 8'h04; req_dat = 32'd3; end
      S_TRN_ON:  begin req_off = 8'h08; req_dat = 32'd1; end
      S_POLL:    begin req_off = 8'h08; req_rd = 1'b1; end
      S_TRN_OFF: req_off = 8'h08;
      S_SEL_TST: begin req_off = 8'h04; req_dat = 32'd5; end
      S_CLR:     begin req_off = 8'h10; req_dat = {31'b0, ~step_q}; end
      S_RD_ERR:  begin req_off = 8'h14; req_rd = 1'b1; end
      S_RD_DAT:  begin req_off = 8'h18; req_rd = 1'b1; end
      S_SEL_WRK: begin req_off = 8'h04; req_dat = 32'd1; end
      S_RETRY:   req_off = step_q ? 8'h04 : 8'h08;
      S_DOWN:    req_off = step_q ? 8'h00 : 8'h04;
      default:   has_bus = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pend_d      = pend_q;
    to_d        = to_q;
    poll_d      = poll_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    fail_d      = fail_q;
    tst_err_d   = tst_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    stop_pend_d = stop_pend_q | stop_live;

    if (has_bus) begin
      if (!pend_q) begin
        if (stop_now) begin
          state_d = S_DOWN;
        end else if (state_q == S_RETRY && !step_q && 32'(retry_q) >= MAX_RETRY) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          if (state_q == S_RETRY && !step_q) retry_d = retry_q + 2'd1;
          pend_d  = 1'b1;
          to_d    = '0;
          addr_d  = BASE_ADDR + {24'b0, req_off};
          wdata_d = req_dat;
          wen_d   = ~req_rd;
          ren_d   = req_rd;
        end
      end else if (!(wen_q || ren_q)) begin
        // An ack in the strobe cycle itself is not a completion.
        if (bus.m_ack_i || to_q == TW'(ACK_TO - 1)) begin
          pend_d = 1'b0;
          if (stop_now) begin
            state_d = S_DOWN;
          end else if (!bus.m_ack_i || bus.m_err_i) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            case (state_q)
              S_EN:      state_d = S_SEL_TRN;
              S_SEL_TRN: state_d = S_TRN_ON;
              S_TRN_ON:  state_d = S_POLL;
              S_POLL: begin
                if (bus.m_rdata_i[4])                state_d = S_TRN_OFF;
                else if (poll_q == PW'(POLL_MAX - 1)) state_d = S_RETRY;
                else                                  poll_d  = poll_q + PW'(1);
              end
              S_TRN_OFF: state_d = S_SEL_TST;
              S_SEL_TST: state_d = S_CLR;
              S_CLR:     if (step_q) state_d = S_WAIT; else step_d = 1'b1;
              S_RD_ERR: begin
                tst_err_d = bus.m_rdata_i;
                state_d   = S_RD_DAT;
              end
              S_RD_DAT:  state_d = (tst_err_q == '0 && bus.m_rdata_i >= MIN_DAT)
                                   ? S_SEL_WRK : S_RETRY;
              S_SEL_WRK: state_d = S_UP;
              S_RETRY:   if (step_q) state_d = S_SEL_TRN; else step_d = 1'b1;
              S_DOWN: begin
                if (step_q) begin
                  state_d = S_IDLE;
                  retry_d = '0;
                end else begin
                  step_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge && !stop_i) begin
            state_d = S_EN;
            retry_d = '0;
            fail_d  = 1'b0;
          end
        end
        S_WAIT: begin
          if (stop_now)                        state_d = S_DOWN;
          else if (wait_q == WW'(TEST_CYC - 1)) state_d = S_RD_ERR;
          else                                  wait_d  = wait_q + WW'(1);
        end
        S_UP:   if (stop_now) state_d = S_DOWN;
        S_FAIL: begin
          if (stop_i) begin
            state_d = S_DOWN;
            fail_d  = 1'b0;
          end else if (start_edge) begin
            state_d = S_EN;
            fail_d  = 1'b0;
            retry_d = '0;
          end
        end
        default: ;
      endcase
    end

    if (state_d != state_q) begin
      step_d = 1'b0;
      if (state_d == S_POLL) poll_d = '0;
      if (state_d == S_WAIT) wait_d = '0;
    end
    if (state_d == S_DOWN || state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      pend_q      <= 1'b0;
      to_q        <= '0;
      poll_q      <= '0;
      wait_q      <= '0;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      tst_err_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      start_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      to_q        <= to_d;
      poll_q      <= poll_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      tst_err_q   <= tst_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      start_q     <= start_i;
      stop_pend_q <= stop_pend_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_UP) && (state_d != S_FAIL);
      link_up_q   <= (state_d == S_UP);
    end
  end

  assign bus.m_addr_o  = addr_q;
  assign bus.m_wdata_o = wdata_q;
  assign bus.m_sel_o   = 4'hF;
  assign bus.m_wen_o   = wen_q;
  assign bus.m_ren_o   = ren_q;
  assign link_up_o     = link_up_q;
  assign busy_o        = busy_q;
  assign fail_o        = fail_q;
  assign state_o       = state_q;
  assign retry_o       = retry_q;
  assign tst_err_o     = tst_err_q;
endmodule

// File: tb/tb_daisy_link_ctrl.sv
// Directed bench for daisy_link_ctrl with a register-space slave model that
// logs every bus access as {wen, addr[7:0], wdata[15:0]}.
module tb_daisy_link_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i;
  logic        link_up, busy, fail;
  logic [3:0]  state;
  logic [1:0]  retry;
  logic [31:0] tst_err;

  always #5 clk = ~clk;

  daisy_link_ctrl_if bus ();

  daisy_link_ctrl #(
    .BASE_ADDR (32'h0),
    .POLL_MAX  (4),
    .TEST_CYC  (8),
    .MIN_DAT   (1000),
    .MAX_RETRY (1),
    .ACK_TO    (16)
  ) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .bus       (bus),
    .link_up_o (link_up),
    .busy_o    (busy),
    .fail_o    (fail),
    .state_o   (state),
    .retry_o   (retry),
    .tst_err_o (tst_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          polls = 0;
  int          trn_on_cnt = 0;
  int          trained_at = 3;
  logic [31:0] err_a = 0, err_b = 0, dat_val = 5000;
  bit          no_ack = 0;
  bit          ack_pend = 0;
  logic [31:0] resp = 0;
  logic [31:0] log_q[$];
  int          log_cyc[$];

  logic [31:0] exp1 [13] = '{32'h8000_0003, 32'h8004_0003, 32'h8008_0001,
                             32'h0008_0000, 32'h0008_0000, 32'h0008_0000,
                             32'h8008_0000, 32'h8004_0005, 32'h8010_0001,
                             32'h8010_0000, 32'h0014_0000, 32'h0018_0000,
                             32'h8004_0001};
  logic [31:0] exp2 [15] = '{32'h8000_0003, 32'h8004_0003, 32'h8008_0001,
                             32'h0008_0000, 32'h0008_0000, 32'h0008_0000, 32'h0008_0000,
                             32'h8008_0000, 32'h8004_0000,
                             32'h8004_0003, 32'h8008_0001,
                             32'h0008_0000, 32'h0008_0000, 32'h0008_0000, 32'h0008_0000};

  // Slave: ack (unless disabled) in the cycle after each strobe.
  always @(negedge clk) begin
    cyc++;
    bus.m_ack_i = 1'b0;
    bus.m_err_i = 1'b0;
    if (rst) begin
      ack_pend = 0;
    end else begin
      if (ack_pend) begin
        ack_pend = 0;
        if (!no_ack) begin
          bus.m_ack_i   = 1'b1;
          bus.m_rdata_i = resp;
        end
      end
      if (bus.m_wen_o || bus.m_ren_o) begin
        log_q.push_back({bus.m_wen_o, 7'b0, bus.m_addr_o[7:0],
                         bus.m_wen_o ? bus.m_wdata_o[15:0] : 16'h0});
        log_cyc.push_back(cyc);
        ack_pend = 1;
        resp = '0;
        if (bus.m_wen_o) begin
          if (bus.m_addr_o == 32'h0 && bus.m_wdata_o == 32'd3) trn_on_cnt = 0;
          if (bus.m_addr_o == 32'h8 && bus.m_wdata_o == 32'd1) begin
            polls = 0;
            trn_on_cnt++;
          end
        end else begin
          case (bus.m_addr_o[7:0])
            8'h08: begin
              polls++;
              resp = (trained_at != 0 && polls >= trained_at) ? 32'h10 : 32'h0;
            end
            8'h14:   resp = (trn_on_cnt <= 1) ? err_a : err_b;
            8'h18:   resp = dat_val;
            default: resp = '0;
          endcase
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    for (int i = 0; i < budget && state !== s; i++) tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n0;
    int dt;
    rst = 1'b1;
    start_i = 1'b0;
    stop_i = 1'b0;
    bus.m_ack_i = 1'b0;
    bus.m_err_i = 1'b0;
    bus.m_rdata_i = '0;
    tick();
    tick();
    check("rst state", state, 0);
    check("rst link_up", link_up, 0);
    check("rst busy", busy, 0);
    check("rst fail", fail, 0);
    check("rst retry", retry, 0);
    check("rst tst_err", tst_err, 0);
    check("rst sel", bus.m_sel_o, 4'hF);
    check("rst strobes", {bus.m_wen_o, bus.m_ren_o}, 0);
    rst = 1'b0;
    tick();

    // Clean bring-up, trained on the third poll
    log_q.delete();
    pulse_start();
    wait_state(12, 500);
    check("t1 state", state, 12);
    check("t1 link_up", link_up, 1);
    check("t1 busy", busy, 0);
    check("t1 retry", retry, 0);
    check("t1 nlog", log_q.size(), 13);
    for (int i = 0; i < 13; i++) check($sformatf("t1 log%0d", i), log_at(i), exp1[i]);

    // Stop from UP
    log_q.delete();
    pulse_stop();
    check("stopup state", state, 14);
    check("stopup link_up", link_up, 0);
    wait_state(0, 100);
    check("stopup idle", state, 0);
    check("stopup nlog", log_q.size(), 2);
    check("stopup log0", log_at(0), 32'h8004_0000);
    check("stopup log1", log_at(1), 32'h8000_0000);

    // Training never completes: one retry then FAIL
    trained_at = 0;
    log_q.delete();
    pulse_start();
    wait_state(15, 1000);
    check("t2 state", state, 15);
    check("t2 fail", fail, 1);
    check("t2 link_up", link_up, 0);
    check("t2 busy", busy, 0);
    check("t2 retry", retry, 1);
    check("t2 nlog", log_q.size(), 15);
    for (int i = 0; i < 15; i++) check($sformatf("t2 log%0d", i), log_at(i), exp2[i]);

    // Stop from FAIL clears fail_o and tears down
    pulse_stop();
    check("stopfail state", state, 14);
    check("stopfail fail", fail, 0);
    wait_state(0, 100);
    check("stopfail idle", state, 0);
    check("stopfail retry", retry, 0);

    // Error count on first attempt, pass on the retry
    trained_at = 1;
    err_a = 2;
    err_b = 0;
    pulse_start();
    wait_state(13, 500);
    check("t3 retry state", state, 13);
    check("t3 tst_err first", tst_err, 2);
    wait_state(12, 500);
    check("t3 up", state, 12);
    check("t3 link_up", link_up, 1);
    check("t3 retry", retry, 1);
    check("t3 tst_err", tst_err, 0);
    pulse_stop();
    wait_state(0, 100);
    check("t3 idle", state, 0);
    err_a = 0;

    // Stop during WAIT
    pulse_start();
    wait_state(8, 500);
    check("tw wait", state, 8);
    log_q.delete();
    pulse_stop();
    check("tw down", state, 14);
    wait_state(0, 100);
    check("tw idle", state, 0);
    check("tw nlog", log_q.size(), 2);
    check("tw log0", log_at(0), 32'h8004_0000);
    check("tw log1", log_at(1), 32'h8000_0000);

    // Ack timeout on the first write
    no_ack = 1;
    log_q.delete();
    pulse_start();
    for (int i = 0; i < 60 && fail !== 1'b1; i++) tick();
    dt = (log_cyc.size() > 0) ? cyc - log_cyc[log_cyc.size() - log_q.size()] : -1;
    check("to fail", fail, 1);
    check("to latency", dt, 17);
    repeat (10) tick();
    check("to nstrobe", log_q.size(), 1);
    check("to state", state, 15);
    check("to busy", busy, 0);
    no_ack = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("to restart state", state, 1);
    check("to restart fail", fail, 0);
    wait_state(12, 500);
    check("to restart up", state, 12);

    // Asynchronous reset while a write strobe is out
    log_q.delete();
    pulse_stop();
    for (int i = 0; i < 20 && bus.m_wen_o !== 1'b1; i++) tick();
    check("ar strobe seen", bus.m_wen_o, 1);
    rst = 1'b1;
    #1;
    check("ar wen", bus.m_wen_o, 0);
    check("ar ren", bus.m_ren_o, 0);
    check("ar state", state, 0);
    check("ar busy", busy, 0);
    check("ar link_up", link_up, 0);
    check("ar retry", retry, 0);
    check("ar addr", bus.m_addr_o, 0);
    n0 = log_q.size();
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("ar quiet", log_q.size(), n0);
    check("ar idle", state, 0);
    pulse_start();
    check("ar restart strobe", log_q.size(), n0 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/daisy_link_ctrl.md
Name: daisy_link_ctrl

Overview:
- Bring-up sequencer for the daisy-chain serial link.
- Acts as a system-bus master on the daisy block's register space. It enables TX/RX, runs RX training, runs a PRBS test window and checks error/data counters, then switches the TX selector to working data.
- Reports link state to software and to the sync/acquisition logic. Retries failed bring-up up to a limit.

Parameters:
- BASE_ADDR, 32'h0, base added to all register offsets.
- POLL_MAX, 1024, maximum reads of the trained flag before a training failure.
- TEST_CYC, 65536, test window length in sys_clk cycles.
- MIN_DAT, 1000, minimum received test-word count for a pass.
- MAX_RETRY, 3, retries after the first attempt before FAIL.
- ACK_TO, 16, cycles to wait for bus ack before a bus fault.

Ports:
- sys_clk_i  in  1  system clock.
- sys_rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  level; rising edge in IDLE or FAIL starts bring-up.
- stop_i  in  1  pulse; tears the link down from any non-IDLE state.
- m_addr_o  out  32  bus address.
- m_wdata_o  out  32  bus write data.
- m_sel_o  out  4  byte select; always 4'hF.
- m_wen_o  out  1  write strobe, one-cycle pulse.
- m_ren_o  out  1  read strobe, one-cycle pulse.
- m_rdata_i  in  32  read data.
- m_ack_i  in  1  bus acknowledge.
- m_err_i  in  1  bus error.
- link_up_o  out  1  link trained, tested and in working mode.
- busy_o  out  1  sequence in progress.
- fail_o  out  1  sticky; retries exhausted or bus fault.
- state_o  out  4  current FSM state code.
- retry_o  out  2  retries used in the current bring-up.
- tst_err_o  out  32  last error count read.

Behaviour:
- Reset: all outputs 0; m_sel_o = 4'hF; FSM in IDLE.
- Bus transaction rules:
  - One outstanding transaction at a time.
  - Strobe asserts for exactly one cycle with address/data already valid. Address/data are held until ack.
  - Completion is the first cycle with m_ack_i=1 at or after the cycle following the strobe.
  - m_err_i=1 at ack, or no ack within ACK_TO cycles of the strobe → bus fault: immediate FAIL with fail_o=1, no retry.
- Register writes (offset:value) and state codes:
  - 0 IDLE.
  - 1 EN: write 0x00 = 3 (tx_en, rx_en).
  - 2 SEL_TRN: write 0x04 = 3 (training pattern 0x00FF).
  - 3 TRN_ON: write 0x08 = 1.
  - 4 POLL: read 0x08.
    - Bit 4 set → 5.
    - Else increment poll counter and read again on the next cycle.
    - poll counter reaching POLL_MAX → RETRY.
  - 5 TRN_OFF: write 0x08 = 0.
  - 6 SEL_TST: write 0x04 = 5 (random test data).
  - 7 CLR: write 0x10 = 1, then write 0x10 = 0.
  - 8 WAIT: count TEST_CYC cycles; no bus activity.
  - 9 RD_ERR: read 0x14 and latch into tst_err_o.
  - 10 RD_DAT: read 0x18.
    - Pass if tst_err_o == 0 and dat >= MIN_DAT (32-bit unsigned compare) → 11.
    - Otherwise → RETRY.
  - 11 SEL_WRK: write 0x04 = 1 → 12.
  - 12 UP: link_up_o=1; stays until stop_i.
  - 13 RETRY:
    - retry_o == MAX_RETRY → 15.
    - Else retry_o++, write 0x08 = 0, write 0x04 = 0, then → 2.
  - 14 DOWN: write 0x04 = 0, write 0x00 = 0 → IDLE; clears link_up_o and retry_o.
  - 15 FAIL: fail_o=1, busy_o=0.
- busy_o=1 in states 1–11, 13, 14.
- link_up_o drops on the cycle the FSM leaves UP.
- stop_i:
  - In any state other than IDLE/DOWN, the current bus transaction completes or times out, then the FSM goes to DOWN.
  - In IDLE, ignored.
  - In FAIL, goes to DOWN and clears fail_o.
- start_i is edge-detected with one register.
  - Starting from FAIL clears fail_o and retry_o.
  - start_i while busy or UP is ignored.
- Simultaneous start_i edge and stop_i: stop wins.
- Poll counter and WAIT counter reset on every entry to their state.
- Counters use saturating widths sized by $clog2 of the parameter.
- Asynchronous reset mid-transaction aborts immediately. Strobes deassert and no further bus access occurs. The daisy block's registers are left as they were; software issues stop_i/start_i.

Test Plan:
- Slave model acks 1 cycle after strobe; trained bit set on 3rd poll; counters err=0, dat=5000 → writes in order 0x00=3, 0x04=3, 0x08=1, three reads of 0x08, 0x08=0, 0x04=5, 0x10=1, 0x10=0, reads 0x14 and 0x18, 0x04=1. Then link_up_o=1, state_o=12, retry_o=0.
- Trained bit never set, POLL_MAX=4, MAX_RETRY=1 → 4 polls, retry writes 0x08=0 and 0x04=0, retry_o=1, 4 more polls, then fail_o=1, state_o=15, link_up_o=0.
- err=2 on first attempt and err=0, dat=5000 on the second → tst_err_o=2 after the first attempt. Link up with retry_o=1 and tst_err_o=0.
- Slave never acks the first write, ACK_TO=16 → m_wen_o pulses once, fail_o=1 17 cycles later, no further strobes. Then start_i edge restarts from EN with fail_o=0.
- stop_i in UP → writes 0x04=0 then 0x00=0, link_up_o=0, returns to IDLE. stop_i during WAIT → DOWN right after the WAIT entry.
- Reset asserted mid-write while strobe is pending → all outputs 0 asynchronously, FSM in IDLE, no strobe after deassert until a start_i edge.
